// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx transmitter between NUM_REQ packet sources. Requesters
//   are picked round-robin, and the grant stays locked to one requester until
//   the word it flagged as last has been fully shifted out. Each word goes
//   through the same sequence: a valid/ready capture, a one-cycle wr_en pulse
//   to uart_tx, then a wait for tx_busy to rise and fall again.
//
//   Optional feature (macro UART_TX_ARB_CHID_EN): each packet is preceded by a
//   header word that carries the grant index, zero-extended to DATA_WIDTH.
//   The header is not counted in words_sent and does not assert req_ready.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_enable         allows new grants; a packet already granted always finishes
//   i_req_valid      per-requester word valid
//   i_req_data       packed words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_req_last       per-requester last-word-of-packet flag
//   o_req_ready      per-requester ready (only the granted bit, only in FETCH)
//   o_grant          one-hot owner, held for the whole packet
//   o_active         |o_grant
//   o_tx_data        word presented to uart_tx data_in
//   o_tx_wr_en       one-cycle start pulse to uart_tx
//   i_tx_busy        busy flag from uart_tx
//   o_words_sent     payload words completed (wraps 0xFFFF -> 0)
//   o_busy_timeout   sticky; set when tx_busy never rose in WAIT_BUSY
//   o_state          current FSM state (debug)
//
// Handshake: a word moves from requester i when i_req_valid[i] and
//   o_req_ready[i] are both 1 at a rising clk edge. Ready does not depend on
//   valid, and a valid that is not granted is ignored.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_enable,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_active,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic                          o_tx_wr_en,
  input  logic                          i_tx_busy,
  output logic [15:0]                   o_words_sent,
  output logic                          o_busy_timeout,
  output logic [2:0]                    o_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BUSY_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
`ifdef UART_TX_ARB_CHID_EN
    , S_HDR     = 3'd5
`endif
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  state_t                  w_done_state;

  logic [NUM_REQ-1:0]      r_grant;
  logic [IDX_W-1:0]        r_ptr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_last;
  logic [15:0]             r_words_sent;
  logic                    r_busy_timeout;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic                    w_is_hdr;

  logic [NUM_REQ-1:0]      w_pick_oh;
  logic [IDX_W-1:0]        w_grant_idx;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_timeout;
  logic                    w_word_done;

`ifdef UART_TX_ARB_CHID_EN
  logic                    r_is_hdr;
  assign w_is_hdr = r_is_hdr;
`else
  assign w_is_hdr = 1'b0;
`endif

  // Round-robin pick: each requester's distance from r_ptr+1 (mod NUM_REQ)
  // is its priority, and the valid requester with the smallest distance wins.
  always_comb begin
    int v_d;
    int v_best_d;
    int v_best_i;
    v_d      = 0;
    v_best_d = NUM_REQ;
    v_best_i = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_d = (i + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
      if (i_req_valid[i] && (v_d < v_best_d)) begin
        v_best_d = v_d;
        v_best_i = i;
      end
    end
    w_pick_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pick_oh[i] = (i == v_best_i);
    end
  end

  // Decode the locked grant into an index, plus the owner's data and last flag.
  always_comb begin
    w_grant_idx = '0;
    w_sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_grant_idx = IDX_W'(i);
        w_sel_data  = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_sel_valid = |(i_req_valid & r_grant);
  assign w_sel_last  = |(i_req_last & r_grant);

  // A timeout stands in for the fall of busy, so both exits share one path.
  assign w_timeout   = (r_state == S_WAIT_BUSY) && !i_tx_busy &&
                       (r_wait_cnt == CNT_W'(BUSY_WAIT - 1));
  assign w_word_done = w_timeout || ((r_state == S_WAIT_DONE) && !i_tx_busy);

  // After a header the payload still has to be fetched. After a payload word,
  // the word's last flag decides the next state.
  always_comb begin
    w_done_state = S_FETCH;
    if (!w_is_hdr && r_last) w_done_state = S_IDLE;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_enable && (|i_req_valid)) begin
`ifdef UART_TX_ARB_CHID_EN
          w_next_state = S_HDR;
`else
          w_next_state = S_FETCH;
`endif
        end
      end
`ifdef UART_TX_ARB_CHID_EN
      S_HDR:       w_next_state = S_ISSUE;
`endif
      S_FETCH:     if (w_sel_valid) w_next_state = S_ISSUE;
      S_ISSUE:     w_next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (i_tx_busy)      w_next_state = S_WAIT_DONE;
        else if (w_timeout) w_next_state = w_done_state;
      end
      S_WAIT_DONE: if (!i_tx_busy) w_next_state = w_done_state;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    o_req_ready = (r_state == S_FETCH) ? r_grant : '0;
    o_tx_wr_en  = (r_state == S_ISSUE);
    o_state     = r_state;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant        <= '0;
      r_ptr          <= IDX_W'(NUM_REQ - 1);
      r_data         <= '0;
      r_last         <= 1'b0;
      r_words_sent   <= '0;
      r_busy_timeout <= 1'b0;
      r_wait_cnt     <= '0;
`ifdef UART_TX_ARB_CHID_EN
      r_is_hdr       <= 1'b0;
`endif
    end else begin
      if ((r_state == S_IDLE) && i_enable && (|i_req_valid)) begin
        r_grant <= w_pick_oh;
      end
`ifdef UART_TX_ARB_CHID_EN
      if (r_state == S_HDR) begin
        r_data   <= {{(DATA_WIDTH-IDX_W){1'b0}}, w_grant_idx};
        r_is_hdr <= 1'b1;
      end
`endif
      if ((r_state == S_FETCH) && w_sel_valid) begin
        r_data <= w_sel_data;
        r_last <= w_sel_last;
`ifdef UART_TX_ARB_CHID_EN
        r_is_hdr <= 1'b0;
`endif
      end
      if (r_state == S_ISSUE) r_wait_cnt <= '0;
      if ((r_state == S_WAIT_BUSY) && !i_tx_busy) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_timeout) r_busy_timeout <= 1'b1;
      if (w_word_done && !w_is_hdr) begin
        r_words_sent <= r_words_sent + 16'd1;
        if (r_last) begin
          r_ptr   <= w_grant_idx;
          r_grant <= '0;
        end
      end
    end
  end

  assign o_grant        = r_grant;
  assign o_active       = |r_grant;
  assign o_tx_data      = r_data;
  assign o_words_sent   = r_words_sent;
  assign o_busy_timeout = r_busy_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int BW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     grant;
  logic              active;
  logic [DW-1:0]     tx_data;
  logic              tx_wr_en;
  logic              tx_busy = 1'b0;
  logic [15:0]       words_sent;
  logic              busy_timeout;
  logic [2:0]        state;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_WAIT(BW)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable),
    .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(req_ready), .o_grant(grant), .o_active(active),
    .o_tx_data(tx_data), .o_tx_wr_en(tx_wr_en), .i_tx_busy(tx_busy),
    .o_words_sent(words_sent), .o_busy_timeout(busy_timeout), .o_state(state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int r, input logic [DW-1:0] d, input logic l);
    req_data[r*DW +: DW] = d;
    req_last[r] = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    tx_busy = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_wr_en"}, 32'(tx_wr_en), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, "_words"}, 32'(words_sent), 32'h0);
    chk({tag, "_timeout"}, 32'(busy_timeout), 32'h0);
    chk({tag, "_active"}, 32'(active), 32'h0);
  endtask

  // Waits (bounded) for the wr_en pulse, checks the word and the owner, then
  // steps past the pulse and checks that it lasted exactly one cycle.
  task automatic wait_issue(input logic [DW-1:0] exp_data, input logic [NR-1:0] exp_grant,
                            input string tag);
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      chk({tag, "_ready_in_grant"}, 32'(req_ready & ~grant), 32'h0);
      if (tx_wr_en) begin
        seen = 1;
        break;
      end
      step();
    end
    chk({tag, "_wr_en_seen"}, 32'(seen), 32'h1);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'(exp_data));
    chk({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    step();
    chk({tag, "_wr_en_one_cycle"}, 32'(tx_wr_en), 32'h0);
  endtask

  task automatic busy_phase(input int n);
    tx_busy = 1'b1;
    repeat (n) step();
    tx_busy = 1'b0;
    step();
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    chk_reset_state("rst1");

    // ---------------- single word from requester 2 ----------------
    enable = 1'b1;
    set_word(2, 16'h00A5, 1'b1);
    req_valid = 4'b0100;
    step();
    chk("t1_grant_after_valid", 32'(grant), 32'h4);
    chk("t1_ready_after_valid", 32'(req_ready), 32'h4);
    chk("t1_active", 32'(active), 32'h1);
    step();
    chk("t1_wr_en", 32'(tx_wr_en), 32'h1);
    chk("t1_tx_data", 32'(tx_data), 32'h00A5);
    chk("t1_ready_in_issue", 32'(req_ready), 32'h0);
    req_valid = '0;
    step();
    chk("t1_wr_en_drop", 32'(tx_wr_en), 32'h0);
    busy_phase(10);
    chk("t1_words", 32'(words_sent), 32'h1);
    chk("t1_grant_released", 32'(grant), 32'h0);
    chk("t1_active_released", 32'(active), 32'h0);
    chk("t1_timeout", 32'(busy_timeout), 32'h0);

    // ---------------- two 3-word packets, requesters 0 and 1 ----------------
    do_reset();
    chk_reset_state("rst2");
    enable = 1'b1;
    set_word(0, 16'h0100, 1'b0);
    set_word(1, 16'h0200, 1'b0);
    req_valid = 4'b0011;
    for (int w = 0; w < 3; w++) begin
      wait_issue(16'h0100 + 16'(w), 4'b0001, "t2_r0");
      if (w < 2) set_word(0, 16'h0101 + 16'(w), (w == 1));
      else       req_valid[0] = 1'b0;
      busy_phase(3);
    end
    chk("t2_words_mid", 32'(words_sent), 32'h3);
    for (int w = 0; w < 3; w++) begin
      wait_issue(16'h0200 + 16'(w), 4'b0010, "t2_r1");
      if (w < 2) set_word(1, 16'h0201 + 16'(w), (w == 1));
      else       req_valid[1] = 1'b0;
      busy_phase(3);
    end
    chk("t2_words", 32'(words_sent), 32'h6);
    chk("t2_grant_released", 32'(grant), 32'h0);

    // ---------------- busy never rises: timeout ----------------
    set_word(2, 16'h0300, 1'b0);
    req_valid = 4'b0100;
    wait_issue(16'h0300, 4'b0100, "t3_w0");
    set_word(2, 16'h0301, 1'b1);
    repeat (BW - 1) step();
    chk("t3_timeout_not_yet", 32'(busy_timeout), 32'h0);
    step();
    chk("t3_timeout_set", 32'(busy_timeout), 32'h1);
    chk("t3_words_after_w0", 32'(words_sent), 32'h7);
    wait_issue(16'h0301, 4'b0100, "t3_w1");
    req_valid = '0;
    repeat (BW) step();
    chk("t3_words", 32'(words_sent), 32'h8);
    chk("t3_grant_released", 32'(grant), 32'h0);
    chk("t3_timeout_sticky", 32'(busy_timeout), 32'h1);

    // ---------------- enable drops mid-packet ----------------
    set_word(3, 16'h0400, 1'b0);
    set_word(0, 16'h0600, 1'b0);
    req_valid = 4'b1001;
    wait_issue(16'h0400, 4'b1000, "t4_w0");
    enable = 1'b0;
    set_word(3, 16'h0401, 1'b1);
    busy_phase(2);
    wait_issue(16'h0401, 4'b1000, "t4_w1");
    req_valid[3] = 1'b0;
    busy_phase(2);
    chk("t4_words", 32'(words_sent), 32'hA);
    for (int k = 0; k < 4; k++) begin
      chk("t4_no_grant_disabled", 32'(grant), 32'h0);
      chk("t4_no_wr_en_disabled", 32'(tx_wr_en), 32'h0);
      step();
    end
    enable = 1'b1;
    step();
    chk("t4_grant_after_enable", 32'(grant), 32'h1);

    // ---------------- reset while in WAIT_DONE ----------------
    wait_issue(16'h0600, 4'b0001, "t5_w0");
    tx_busy = 1'b1;
    step();
    step();
    chk("t5_in_wait_done", 32'(state), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("t5_async");
    tx_busy = 1'b0;
    set_word(0, 16'h0700, 1'b1);
    set_word(2, 16'h0800, 1'b1);
    req_valid = 4'b0101;
    #1;
    rst_n = 1'b1;
    step();
    chk("t5_grant_after_release", 32'(grant), 32'h1);
    wait_issue(16'h0700, 4'b0001, "t5_w1");
    req_valid[0] = 1'b0;
    busy_phase(2);
    chk("t5_words", 32'(words_sent), 32'h1);
    wait_issue(16'h0800, 4'b0100, "t5_w2");
    req_valid = '0;
    busy_phase(2);
    chk("t5_words_end", 32'(words_sent), 32'h2);

`ifdef UART_TX_ARB_CHID_EN
    // ---------------- channel-id header ----------------
    do_reset();
    enable = 1'b1;
    set_word(3, 16'h1234, 1'b1);
    req_valid = 4'b1000;
    wait_issue(16'h0003, 4'b1000, "t6_hdr");
    busy_phase(2);
    chk("t6_words_after_hdr", 32'(words_sent), 32'h0);
    wait_issue(16'h1234, 4'b1000, "t6_payload");
    req_valid = '0;
    busy_phase(2);
    chk("t6_words", 32'(words_sent), 32'h1);
    chk("t6_grant_released", 32'(grant), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
